program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/program_loader_word_assembler.sv | 37 +++
 rtl/program_loader.sv | 151 +++++++++++++++
 tb/tb_program_loader.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants for the UART program loader: FSM state encodings and handshake bytes.
package program_loader_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [STATE_W-1:0] ST_SEND_REQ  = 3'd0;
  localparam logic [STATE_W-1:0] ST_RECV_SIZE = 3'd1;
  localparam logic [STATE_W-1:0] ST_RECV_PROG = 3'd2;
  localparam logic [STATE_W-1:0] ST_SEND_ACK  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE      = 3'd4;

  localparam logic [BYTE_W-1:0] LOADER_REQ = 8'h99;
  localparam logic [BYTE_W-1:0] LOADER_ACK = 8'hAA;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; a last_byte flush emits a
// partial word whose unfilled upper lanes read as zero.
module loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  input  logic              last_byte,
  output logic [WORD_W-1:0] word_c,
  output logic              word_done_c
);

  logic [WORD_W-1:0] lanes_q;
  logic [1:0]        lane_q;

  // Unfilled lanes stay zero, so a flush needs no extra masking.
  always_comb begin
    word_c      = lanes_q | (WORD_W'(byte_data) << {lane_q, 3'b000});
    word_done_c = byte_valid && ((lane_q == 2'd3) || last_byte);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else if (word_done_c) begin
      lanes_q <= '0;
      lane_q  <= '0;
    end else if (byte_valid) begin
      lanes_q <= word_c;
      lane_q  <= lane_q + 2'd1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// UART boot loader: requests a program with 0x99, receives a little-endian size and
// payload, writes it word by word into instruction memory, then acknowledges with 0xAA.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned IMEM_ADDR_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BYTE_W-1:0]          rx_rdata,
  input  logic                       rx_rdata_ready,
  input  logic                       rx_ferr,
  output logic [BYTE_W-1:0]          tx_sdata,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_W-1:0]          imem_wdata,
  output logic                       load_done,
  output logic                       load_error
);

  logic [STATE_W-1:0]         state_q, state_d;
  logic [WORD_W-1:0]          size_q, size_d;
  logic [WORD_W-1:0]          byte_cnt_q, byte_cnt_d, byte_cnt_inc;
  logic [IMEM_ADDR_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic                       addr_full_q, addr_full_d;
  logic                       guard_q, guard_d;

  logic [BYTE_W-1:0]          tx_sdata_d;
  logic                       tx_start_d, imem_we_d, load_done_d, load_error_d;
  logic [IMEM_ADDR_WIDTH-1:0] imem_addr_d;
  logic [WORD_W-1:0]          imem_wdata_d;

  logic              in_recv, byte_ok, last_byte, tx_ready;
  logic [WORD_W-1:0] word_c;
  logic              word_done_c;

  assign in_recv      = (state_q == ST_RECV_SIZE) || (state_q == ST_RECV_PROG);
  assign byte_ok      = rx_rdata_ready && !rx_ferr && in_recv;
  assign byte_cnt_inc = byte_cnt_q + 32'd1;
  assign last_byte    = (state_q == ST_RECV_PROG) && (byte_cnt_inc == size_q);
  // tx_busy is not trusted until the transmitter has had a cycle to raise it.
  assign tx_ready     = !tx_busy && !tx_start && !guard_q;

  loader_word_assembler u_asm (
    .clk         (clk),
    .reset_n     (reset_n),
    .byte_valid  (byte_ok),
    .byte_data   (rx_rdata),
    .last_byte   (last_byte),
    .word_c      (word_c),
    .word_done_c (word_done_c)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    byte_cnt_d   = byte_cnt_q;
    wr_idx_d     = wr_idx_q;
    addr_full_d  = addr_full_q;
    guard_d      = tx_start;
    tx_sdata_d   = tx_sdata;
    tx_start_d   = 1'b0;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    load_done_d  = load_done;
    load_error_d = load_error;

    if (rx_rdata_ready && rx_ferr && in_recv) load_error_d = 1'b1;

    case (state_q)
      ST_SEND_REQ: begin
        if (tx_ready) begin
          tx_sdata_d = LOADER_REQ;
          tx_start_d = 1'b1;
          state_d    = ST_RECV_SIZE;
        end
      end
      ST_RECV_SIZE: begin
        if (word_done_c) begin
          size_d     = word_c;
          byte_cnt_d = '0;
          state_d    = (word_c == '0) ? ST_SEND_ACK : ST_RECV_PROG;
        end
      end
      ST_RECV_PROG: begin
        if (byte_ok) begin
          byte_cnt_d = byte_cnt_inc;
          // Words past the top of memory are dropped rather than wrapped.
          if (word_done_c) begin
            if (addr_full_q) begin
              load_error_d = 1'b1;
            end else begin
              imem_we_d    = 1'b1;
              imem_addr_d  = wr_idx_q;
              imem_wdata_d = word_c;
              if (wr_idx_q == {IMEM_ADDR_WIDTH{1'b1}}) addr_full_d = 1'b1;
              else wr_idx_d = wr_idx_q + IMEM_ADDR_WIDTH'(1);
            end
          end
          if (last_byte) state_d = ST_SEND_ACK;
        end
      end
      ST_SEND_ACK: begin
        if (tx_ready) begin
          tx_sdata_d  = LOADER_ACK;
          tx_start_d  = 1'b1;
          load_done_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: ;
      default: state_d = ST_SEND_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_SEND_REQ;
      size_q      <= '0;
      byte_cnt_q  <= '0;
      wr_idx_q    <= '0;
      addr_full_q <= 1'b0;
      guard_q     <= 1'b0;
      tx_sdata    <= '0;
      tx_start    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      byte_cnt_q  <= byte_cnt_d;
      wr_idx_q    <= wr_idx_d;
      addr_full_q <= addr_full_d;
      guard_q     <= guard_d;
      tx_sdata    <= tx_sdata_d;
      tx_start    <= tx_start_d;
      imem_we     <= imem_we_d;
      imem_addr   <= imem_addr_d;
      imem_wdata  <= imem_wdata_d;
      load_done   <= load_done_d;
      load_error  <= load_error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: a default-size instance and a 4-word instance share the
// UART stimulus; sel chooses which one the monitors and transmitter model follow.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_rdata = '0;
  logic        rx_rdata_ready = 1'b0;
  logic        rx_ferr = 1'b0;
  logic        tx_busy;
  logic        sel = 1'b0;

  logic [7:0]  a_tx_sdata, b_tx_sdata;
  logic        a_tx_start, b_tx_start, a_imem_we, b_imem_we;
  logic [13:0] a_imem_addr;
  logic [1:0]  b_imem_addr;
  logic [31:0] a_imem_wdata, b_imem_wdata;
  logic        a_load_done, b_load_done, a_load_error, b_load_error;

  logic        m_start, m_we, m_done, m_err;
  logic [7:0]  m_sdata;
  logic [31:0] m_addr, m_wdata;

  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  int          back_to_back_tx = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  tx_obs[$];
  wr_t         wr_obs[$];
  wr_t         exp_q[$];
  logic [7:0]  prog_q[$];

  always #5 clk = ~clk;

  program_loader #(.IMEM_ADDR_WIDTH(14)) dut_a (
    .clk(clk), .reset_n(reset_n), .rx_rdata(rx_rdata), .rx_rdata_ready(rx_rdata_ready),
    .rx_ferr(rx_ferr), .tx_sdata(a_tx_sdata), .tx_start(a_tx_start), .tx_busy(tx_busy),
    .imem_we(a_imem_we), .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .load_done(a_load_done), .load_error(a_load_error));

  program_loader #(.IMEM_ADDR_WIDTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .rx_rdata(rx_rdata), .rx_rdata_ready(rx_rdata_ready),
    .rx_ferr(rx_ferr), .tx_sdata(b_tx_sdata), .tx_start(b_tx_start), .tx_busy(tx_busy),
    .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .load_done(b_load_done), .load_error(b_load_error));

  assign m_start = sel ? b_tx_start : a_tx_start;
  assign m_sdata = sel ? b_tx_sdata : a_tx_sdata;
  assign m_we    = sel ? b_imem_we : a_imem_we;
  assign m_addr  = sel ? 32'(b_imem_addr) : 32'(a_imem_addr);
  assign m_wdata = sel ? b_imem_wdata : a_imem_wdata;
  assign m_done  = sel ? b_load_done : a_load_done;
  assign m_err   = sel ? b_load_error : a_load_error;

  // Transmitter model: busy rises the cycle after it samples tx_start.
  always @(posedge clk) begin
    if (!reset_n) busy_cnt <= 0;
    else if (m_start === 1'b1) busy_cnt <= 6;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    wr_t w;
    if (m_start === 1'b1) begin
      tx_obs.push_back(m_sdata);
      if (prev_start === 1'b1) back_to_back_tx++;
    end
    prev_start = m_start;
    if (m_we === 1'b1) begin
      w.addr = m_addr;
      w.data = m_wdata;
      wr_obs.push_back(w);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ferr);
    tick();
    rx_rdata = b;
    rx_rdata_ready = 1'b1;
    rx_ferr = ferr;
    tick();
    rx_rdata_ready = 1'b0;
    rx_ferr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic wait_tx(output bit got, output logic [7:0] b, output int cyc);
    got = 1'b0;
    b = '0;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx_obs.size() != 0) begin
        b = tx_obs.pop_front();
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_rdata_ready = 1'b0;
    rx_ferr = 1'b0;
    repeat (3) tick();
    tx_obs.delete();
    wr_obs.delete();
    exp_q.delete();
    reset_n = 1'b1;
  endtask

  // Sends size then prog_q, pushing the words memory should receive (up to limit).
  task automatic drive_program(input logic [31:0] size, input int limit);
    wr_t e;
    logic [31:0] w;
    int n;
    n = prog_q.size();
    for (int i = 0; i < n; i += 4) begin
      w = '0;
      for (int j = 0; j < 4 && (i + j) < n; j++) w |= 32'(prog_q[i+j]) << (8 * j);
      if ((i / 4) < limit) begin
        e.addr = 32'(i / 4);
        e.data = w;
        exp_q.push_back(e);
      end
    end
    send_word(size);
    for (int i = 0; i < n; i++) send_byte(prog_q[i], 1'b0);
  endtask

  task automatic test_reset();
    bit got;
    logic [7:0] b;
    int cyc;
    sel = 1'b0;
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({a_tx_start, a_tx_sdata, a_imem_we, a_imem_addr, a_imem_wdata, a_load_done, a_load_error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b sdata=%h we=%b addr=%h wdata=%h done=%b err=%b, want all 0",
               a_tx_start, a_tx_sdata, a_imem_we, a_imem_addr, a_imem_wdata, a_load_done, a_load_error);
    end
    tx_obs.delete();
    wr_obs.delete();
    reset_n = 1'b1;
    wait_tx(got, b, cyc);
    checks++;
    if (!got || cyc > 2) begin
      errors++;
      $display("FAIL req_latency: got=%0d after %0d cycles, want within 2", got, cyc);
    end
    checks++;
    if (b !== LOADER_REQ) begin
      errors++;
      $display("FAIL req_byte: got %h want %h", b, LOADER_REQ);
    end
    repeat (30) tick();
    checks++;
    if (tx_obs.size() != 0) begin
      errors++;
      $display("FAIL req_once: %0d extra tx_start pulses, want 0", tx_obs.size());
    end
  endtask

  task automatic test_basic();
    bit got;
    logic [7:0] b;
    int cyc;
    wr_t e, o;
    sel = 1'b0;
    do_reset();
    wait_tx(got, b, cyc);
    checks++;
    if (b !== LOADER_REQ) begin
      errors++;
      $display("FAIL basic_req: got %h want %h", b, LOADER_REQ);
    end
    prog_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    drive_program(32'd8, 1 << 14);
    wait_tx(got, b, cyc);
    checks++;
    if (b !== LOADER_ACK) begin
      errors++;
      $display("FAIL basic_ack: got %h want %h", b, LOADER_ACK);
    end
    tick();
    checks++;
    if ({m_done, m_err} !== 2'b10) begin
      errors++;
      $display("FAIL basic_flags: got done=%b err=%b want done=1 err=0", m_done, m_err);
    end
    checks++;
    if (wr_obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_wr_count: got %0d want %0d", wr_obs.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && wr_obs.size() != 0) begin
      e = exp_q.pop_front();
      o = wr_obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic_wr: got addr=%h data=%h want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    wr_obs.delete();
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    repeat (10) tick();
    checks++;
    if (wr_obs.size() != 0 || tx_obs.size() != 0 || m_done !== 1'b1) begin
      errors++;
      $display("FAIL done_terminal: got writes=%0d tx=%0d done=%b want 0 0 1", wr_obs.size(), tx_obs.size(), m_done);
    end
  endtask

  task automatic test_size_zero();
    bit got;
    logic [7:0] b;
    int cyc;
    sel = 1'b0;
    do_reset();
    wait_tx(got, b, cyc);
    prog_q.delete();
    drive_program(32'd0, 1 << 14);
    wait_tx(got, b, cyc);
    checks++;
    if (!got || b !== LOADER_ACK || cyc > 4) begin
      errors++;
      $display("FAIL zero_ack: got=%0d byte=%h after %0d cycles, want %h within 4", got, b, cyc, LOADER_ACK);
    end
    tick();
    checks++;
    if (wr_obs.size() != 0 || m_done !== 1'b1 || m_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_state: got writes=%0d done=%b err=%b want 0 1 0", wr_obs.size(), m_done, m_err);
    end
  endtask

  task automatic test_partial();
    bit got;
    logic [7:0] b;
    int cyc;
    wr_t e, o;
    sel = 1'b0;
    do_reset();
    wait_tx(got, b, cyc);
    prog_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    drive_program(32'd5, 1 << 14);
    wait_tx(got, b, cyc);
    checks++;
    if (b !== LOADER_ACK) begin
      errors++;
      $display("FAIL partial_ack: got %h want %h", b, LOADER_ACK);
    end
    checks++;
    if (wr_obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL partial_wr_count: got %0d want %0d", wr_obs.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && wr_obs.size() != 0) begin
      e = exp_q.pop_front();
      o = wr_obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL partial_wr: got addr=%h data=%h want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_overflow();
    bit got;
    logic [7:0] b;
    int cyc;
    wr_t e, o;
    sel = 1'b1;
    do_reset();
    wait_tx(got, b, cyc);
    prog_q.delete();
    for (int i = 0; i < 20; i++) prog_q.push_back(8'(i + 1));
    drive_program(32'd20, 4);
    wait_tx(got, b, cyc);
    checks++;
    if (b !== LOADER_ACK) begin
      errors++;
      $display("FAIL ovf_ack: got %h want %h", b, LOADER_ACK);
    end
    tick();
    checks++;
    if ({m_done, m_err} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_flags: got done=%b err=%b want 1 1", m_done, m_err);
    end
    checks++;
    if (wr_obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ovf_wr_count: got %0d want %0d", wr_obs.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && wr_obs.size() != 0) begin
      e = exp_q.pop_front();
      o = wr_obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ovf_wr: got addr=%h data=%h want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got;
    logic [7:0] b;
    int cyc;
    sel = 1'b0;
    do_reset();
    wait_tx(got, b, cyc);
    send_word(32'd8);
    for (int i = 0; i < 6; i++) send_byte(8'(8'hA0 + i), 1'b0);
    checks++;
    if (wr_obs.size() != 1) begin
      errors++;
      $display("FAIL mid_pre_writes: got %0d want 1", wr_obs.size());
    end
    reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({a_tx_start, a_tx_sdata, a_imem_we, a_imem_addr, a_imem_wdata, a_load_done, a_load_error} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got start=%b sdata=%h we=%b addr=%h wdata=%h done=%b err=%b, want all 0",
               a_tx_start, a_tx_sdata, a_imem_we, a_imem_addr, a_imem_wdata, a_load_done, a_load_error);
    end
    tx_obs.delete();
    wr_obs.delete();
    exp_q.delete();
    reset_n = 1'b1;
    wait_tx(got, b, cyc);
    checks++;
    if (!got || b !== LOADER_REQ) begin
      errors++;
      $display("FAIL mid_restart_req: got=%0d byte=%h want %h", got, b, LOADER_REQ);
    end
    prog_q.delete();
    drive_program(32'd0, 1 << 14);
    wait_tx(got, b, cyc);
    tick();
    checks++;
    if (b !== LOADER_ACK || m_done !== 1'b1 || wr_obs.size() != 0) begin
      errors++;
      $display("FAIL mid_restart_load: got ack=%h done=%b writes=%0d want %h 1 0", b, m_done, wr_obs.size(), LOADER_ACK);
    end
  endtask

  task automatic test_ferr();
    bit got;
    logic [7:0] b;
    int cyc;
    wr_t e, o;
    sel = 1'b0;
    do_reset();
    wait_tx(got, b, cyc);
    send_word(32'd4);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    checks++;
    if (m_err !== 1'b0) begin
      errors++;
      $display("FAIL ferr_pre: got err=%b want 0", m_err);
    end
    send_byte(8'h77, 1'b1);
    checks++;
    if (m_err !== 1'b1) begin
      errors++;
      $display("FAIL ferr_flag: got err=%b want 1", m_err);
    end
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    e.addr = 32'd0;
    e.data = 32'h44332211;
    exp_q.push_back(e);
    wait_tx(got, b, cyc);
    checks++;
    if (b !== LOADER_ACK) begin
      errors++;
      $display("FAIL ferr_ack: got %h want %h", b, LOADER_ACK);
    end
    checks++;
    if (wr_obs.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ferr_wr_count: got %0d want %0d", wr_obs.size(), exp_q.size());
    end
    while (exp_q.size() != 0 && wr_obs.size() != 0) begin
      e = exp_q.pop_front();
      o = wr_obs.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ferr_wr: got addr=%h data=%h want addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_tx_spacing();
    checks++;
    if (back_to_back_tx != 0) begin
      errors++;
      $display("FAIL tx_spacing: got %0d consecutive tx_start cycles, want 0", back_to_back_tx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_size_zero();
    test_partial();
    test_overflow();
    test_reset_mid();
    test_ferr();
    test_tx_spacing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
